// File: rtl/reg_file_param.sv
// Parametrised register file: two registered read ports, one write port, and a self-initialising sweep after reset.
// Optional write-through forwarding on read/write address collisions is compiled in with `define REGFILE_BYPASS_EN.
module reg_file_param #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic [WIDTH-1:0]  IN,
  input  logic [ADDR_W-1:0] INaddr,
  input  logic              WRITE_EN,
  input  logic [ADDR_W-1:0] OUT1addr,
  input  logic [ADDR_W-1:0] OUT2addr,
  output logic [WIDTH-1:0]  OUT1,
  output logic [WIDTH-1:0]  OUT2,
  output logic              READY
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t             state, state_next;
  logic [ADDR_W-1:0]  ptr, ptr_next;
  logic [WIDTH-1:0]   init_val;
  logic [WIDTH-1:0]   regs [DEPTH];

  // The widened copy of ptr covers both the zero-extend and the truncate case.
  logic [ADDR_W+WIDTH-1:0] ptr_ext;
  assign ptr_ext  = {{WIDTH{1'b0}}, ptr};
  assign init_val = ptr_ext[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    case (state)
      INIT: begin
        ptr_next = ptr + 1'b1;
        if (ptr == LAST) state_next = RUN;
      end
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  // NOTE: the storage array has no reset; the post-reset sweep gives it defined contents instead.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      if (state == INIT)  regs[ptr]    <= init_val;
      else if (WRITE_EN)  regs[INaddr] <= IN;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      OUT1  <= '0;
      OUT2  <= '0;
      READY <= 1'b0;
    end else if (state == INIT) begin
      OUT1 <= '0;
      OUT2 <= '0;
      if (ptr == LAST) READY <= 1'b1;
    end else begin
`ifdef REGFILE_BYPASS_EN
      OUT1 <= (WRITE_EN && (OUT1addr == INaddr)) ? IN : regs[OUT1addr];
      OUT2 <= (WRITE_EN && (OUT2addr == INaddr)) ? IN : regs[OUT2addr];
`else
      // Reads see the array before this edge's write lands (read-before-write).
      OUT1 <= regs[OUT1addr];
      OUT2 <= regs[OUT2addr];
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: an 8x8 instance and a 4-bit x 32 instance, scoreboard-checked one cycle after each step.
module tb_reg_file_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit x 8 instance
  logic       r8 = 1'b1, we8 = 1'b0;
  logic [7:0] in8 = '0, o18, o28;
  logic [2:0] ia8 = '0, a18 = '0, a28 = '0;
  logic       rdy8;

  // 4-bit x 32 instance
  logic       r4 = 1'b1, we4 = 1'b0;
  logic [3:0] in4 = '0, o14, o24;
  logic [4:0] ia4 = '0, a14 = '0, a24 = '0;
  logic       rdy4;

  reg_file_param #(.WIDTH(8), .ADDR_W(3)) dut8 (
    .clk(clk), .RESET(r8), .IN(in8), .INaddr(ia8), .WRITE_EN(we8),
    .OUT1addr(a18), .OUT2addr(a28), .OUT1(o18), .OUT2(o28), .READY(rdy8)
  );

  reg_file_param #(.WIDTH(4), .ADDR_W(5)) dut4 (
    .clk(clk), .RESET(r4), .IN(in4), .INaddr(ia4), .WRITE_EN(we4),
    .OUT1addr(a14), .OUT2addr(a24), .OUT1(o14), .OUT2(o24), .READY(rdy4)
  );

  typedef enum int {P_OUT1, P_OUT2, P_READY} port_t;
  typedef struct {
    string       tag;
    int          dut;   // 8 or 4
    port_t       port;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int checks = 0;
  int errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic push(input string tag, input int dut, input port_t port, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag; e.dut = dut; e.port = port; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic expect8(input string tag, input logic [7:0] e1, input logic [7:0] e2, input logic er);
    push({tag, ".out1"},  8, P_OUT1,  32'(e1));
    push({tag, ".out2"},  8, P_OUT2,  32'(e2));
    push({tag, ".ready"}, 8, P_READY, 32'(er));
  endtask

  function automatic logic [31:0] observe(input int dut, input port_t port);
    logic [31:0] v;
    v = 'x;
    if (dut == 8) begin
      case (port)
        P_OUT1:  v = 32'(o18);
        P_OUT2:  v = 32'(o28);
        default: v = 32'(rdy8);
      endcase
    end else begin
      case (port)
        P_OUT1:  v = 32'(o14);
        P_OUT2:  v = 32'(o24);
        default: v = 32'(rdy4);
      endcase
    end
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then drain every expectation queued for it.
  task automatic tick();
    sb_entry_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.dut, e.port), e.exp);
    end
  endtask

  initial begin
    // Reset held for two edges
    tick();
    expect8("rst", 8'h00, 8'h00, 1'b0);
    tick();

    // Sweep: 8 edges, write pulse on 3rd edge must be ignored
    r8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      we8 = (k == 3); ia8 = 3'd2; in8 = 8'hAA;
      a18 = 3'd2; a28 = 3'd2;
      expect8($sformatf("sweep%0d", k), 8'h00, 8'h00, k == 8);
      tick();
    end
    we8 = 1'b0;

    // Init values
    a18 = 3'd5; a28 = 3'd7;
    expect8("init5_7", 8'h05, 8'h07, 1'b1); tick();
    a18 = 3'd2; a28 = 3'd0;
    expect8("init2_0", 8'h02, 8'h00, 1'b1); tick();

    // Write then read back; a later disabled write must not land
    we8 = 1'b1; ia8 = 3'd3; in8 = 8'hF7; a18 = 3'd0; a28 = 3'd1;
    expect8("wr3", 8'h00, 8'h01, 1'b1); tick();
    we8 = 1'b0; a18 = 3'd3; a28 = 3'd6;
    expect8("rd3", 8'hF7, 8'h06, 1'b1); tick();
    we8 = 1'b0; ia8 = 3'd3; in8 = 8'h11; a18 = 3'd3; a28 = 3'd3;
    expect8("nowr3", 8'hF7, 8'hF7, 1'b1); tick();
    a18 = 3'd3; a28 = 3'd4;
    expect8("rd3b", 8'hF7, 8'h04, 1'b1); tick();

    // Same-address collision on both ports
    we8 = 1'b1; ia8 = 3'd1; in8 = 8'h95; a18 = 3'd1; a28 = 3'd1;
    expect8("coll1", BYPASS ? 8'h95 : 8'h01, BYPASS ? 8'h95 : 8'h01, 1'b1); tick();
    we8 = 1'b0;
    expect8("post1", 8'h95, 8'h95, 1'b1); tick();

    // Collision on one port only
    we8 = 1'b1; ia8 = 3'd4; in8 = 8'h5A; a18 = 3'd4; a28 = 3'd5;
    expect8("coll4", BYPASS ? 8'h5A : 8'h04, 8'h05, 1'b1); tick();
    we8 = 1'b0;
    expect8("post4", 8'h5A, 8'h05, 1'b1); tick();

    // Reset mid-RUN with a simultaneous write that must be dropped
    we8 = 1'b1; ia8 = 3'd6; in8 = 8'h3C; a18 = 3'd7; a28 = 3'd7;
    expect8("wr6", 8'h07, 8'h07, 1'b1); tick();
    we8 = 1'b0; a18 = 3'd6; a28 = 3'd4;
    expect8("rd6", 8'h3C, 8'h5A, 1'b1); tick();
    r8 = 1'b1; we8 = 1'b1; ia8 = 3'd4; in8 = 8'hEE;
    expect8("midrst", 8'h00, 8'h00, 1'b0); tick();
    r8 = 1'b0; we8 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      expect8($sformatf("resweep%0d", k), 8'h00, 8'h00, k == 8);
      tick();
    end
    a18 = 3'd6; a28 = 3'd4;
    expect8("reinit6_4", 8'h06, 8'h04, 1'b1); tick();
    a18 = 3'd1; a28 = 3'd3;
    expect8("reinit1_3", 8'h01, 8'h03, 1'b1); tick();

    // WIDTH=4, ADDR_W=5: 32-edge sweep, truncated init values
    tick();
    r4 = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      push($sformatf("w4sweep%0d", k), 4, P_READY, 32'(k == 32));
      push($sformatf("w4sweep%0d.out1", k), 4, P_OUT1, 32'h0);
      tick();
    end
    a14 = 5'd19; a24 = 5'd16;
    push("w4rd19", 4, P_OUT1, 32'h3);
    push("w4rd16", 4, P_OUT2, 32'h0);
    tick();
    a14 = 5'd31; a24 = 5'd5;
    push("w4rd31", 4, P_OUT1, 32'hF);
    push("w4rd5",  4, P_OUT2, 32'h5);
    tick();
    we4 = 1'b1; ia4 = 5'd31; in4 = 4'hA;
    tick();
    we4 = 1'b0;
    push("w4wrA", 4, P_OUT1, 32'hA);
    tick();
    we4 = 1'b1; ia4 = 5'd31; in4 = 4'hF;
    tick();
    we4 = 1'b0;
    push("w4wrF", 4, P_OUT1, 32'hF);
    push("w4rdy", 4, P_READY, 32'h1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
